serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out frame transmitter. It accepts a `DATA_WIDTH`-bit word over a valid/ready handshake and shifts it onto a single idle-high line as follows:

- one start bit (0);
- the data bits, LSB first;
- an optional even-parity bit;
- one stop bit (1).

Each bit is held for `CLKS_PER_BIT` clocks. It is the transmit end of the team's serial link and drives the line sampled by the matching receiver block.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame; must be ≥1.
- `CLKS_PER_BIT`, default 4: clocks per serial bit; must be ≥1; bit counter width is `$clog2(CLKS_PER_BIT)`, minimum 1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `tx_data`, input, `DATA_WIDTH`: word to send; sampled only on the accept edge.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: block can accept a word; registered.
- `tx_out`, output, 1: serial line; idle high; registered.
- `tx_busy`, output, 1: frame in progress; registered.
- `tx_done`, output, 1: one-cycle pulse when a frame completes; registered.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY (exists only with the macro), STOP.
- **IDLE:**
  - `tx_ready`=1, `tx_out`=1, `tx_busy`=0.
  - Accept occurs on a rising edge with `tx_valid`=1 and `tx_ready`=1.
  - On accept: latch `tx_data` into the shift register, compute parity (`^tx_data`), clear the bit counter, go to START, drop `tx_ready`, raise `tx_busy`.
- **START:** `tx_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA:**
  - `tx_out` = shift register bit 0.
  - After `CLKS_PER_BIT` cycles, shift right by one and increment the bit index.
  - After bit `DATA_WIDTH-1`, go to PARITY (macro defined) or STOP.
- **PARITY:** `tx_out` = XOR of the latched word (even parity), for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP:** `tx_out`=1 for `CLKS_PER_BIT` cycles, then go to IDLE. `tx_done` pulses for exactly the first IDLE cycle.
- **Input changes:**
  - `tx_valid` and `tx_data` are ignored outside IDLE; a word presented while busy is not consumed.
  - Changes to `tx_data` after the accept edge do not affect the frame in flight.
- **Reset:**
  - Asserting `rst` at any time, including mid-frame, immediately forces IDLE.
  - Reset values: `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; shift register and counters cleared.
  - The partial frame is abandoned and never resumed.
- **`tx_ready` during reset:** it holds 1 while `rst` is asserted. No accept can occur until the first rising edge after `rst` deasserts.

## Timing
- Let accept edge = E, P = 1 with the macro else 0, and C = `CLKS_PER_BIT`.
- **Start bit:** `tx_out` falls in the cycle after E (registered output) and occupies cycles E+1 … E+C.
- **Data bit i:** occupies cycles E+(1+i)·C+1 … E+(2+i)·C.
- **Frame length:** (`DATA_WIDTH`+2+P)·C cycles. For 8/4 without parity this is 40 cycles (E+1 … E+40).
- **End of frame:**
  - `tx_done`=1 and `tx_ready`=1 in cycle E+40+1 (8/4, no parity).
  - `tx_busy` falls in the same cycle.
- **Back-to-back:**
  - If `tx_valid` is held high, the next accept is on the edge ending that IDLE cycle.
  - Minimum gap between the stop bit and the next start bit is therefore exactly one idle-high cycle.
- **C = 1:** every state lasts exactly one cycle; no zero-length bits.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- Defined: PARITY state compiled in. The frame carries an even-parity bit between the last data bit and the stop bit, so the frame is `DATA_WIDTH`+3 bits.
- Undefined: no PARITY state and no parity logic. The frame is `DATA_WIDTH`+2 bits; STOP follows the last data bit directly.

## Test plan
- **Reset values:** assert `rst` with no clock edges → `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
- **Single frame, no parity** (8/4, macro off):
  - Stimulus: send 0xA5, sampling `tx_out` mid-bit.
  - Expected sequence: 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once at E+41; `tx_busy` is high E+1 … E+40.
- **Single frame, parity** (macro on):
  - Stimulus: send 0xA5.
  - Expected: the bit after data = 0 (four ones), then stop = 1; frame 44 cycles; `tx_done` at E+45.
- **Second parity case:** send 0x07 with the macro on → parity bit = 1.
- **Back-to-back:**
  - Stimulus: hold `tx_valid` high with 0x3C, then 0xC3.
  - Expected: exactly one idle-high cycle between the first stop bit and the second start bit; both words are transmitted correctly.
- **Busy and mid-frame reset:**
  - Present 0xFF with `tx_valid` during the DATA state of a 0x00 frame → not accepted; line shows only 0x00.
  - Then pulse `rst` mid-frame → `tx_out`=1 immediately; `tx_ready`=1; no `tx_done`.
  - A new 0x5A sent after reset transmits cleanly.

Source files
------------

// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx -- parallel-in, serial-out frame transmitter.
//
// Accepts a DATA_WIDTH-bit word over a valid/ready handshake and shifts it
// onto an idle-high serial line as: start bit (0), data bits LSB first,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature macro: SERIAL_TX_PARITY_EN
//   defined   -> PARITY state compiled in, frame is DATA_WIDTH+3 bits
//   undefined -> no parity logic, frame is DATA_WIDTH+2 bits
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-high reset, forces IDLE immediately
//   tx_data_i   word to send, sampled only on the accept edge
//   tx_valid_i  tx_data_i is valid
//   tx_ready_o  block can accept a word (registered)
//   tx_out_o    serial line, idle high (registered)
//   tx_busy_o   frame in progress (registered)
//   tx_done_o   one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_out_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

`ifdef SERIAL_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif
  logic                   tx_out_q, tx_out_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);

  // Next-state logic: bit timing, bit index and shift register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid_i && tx_ready_q) begin
          shift_d  = tx_data_i;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = even_parity(tx_data_i);
`endif
          cnt_d    = {CNT_W{1'b0}};
          idx_d    = {IDX_W{1'b0}};
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_DATA;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = shift_q >> 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = {IDX_W{1'b0}};
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_STOP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    tx_ready_d = (state_d == ST_IDLE);
    tx_busy_d  = (state_d != ST_IDLE);
    tx_done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    tx_out_d   = 1'b1;
    case (state_d)
      ST_IDLE:   tx_out_d = 1'b1;
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      ST_STOP:   tx_out_d = 1'b1;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      shift_q    <= {DATA_WIDTH{1'b0}};
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_out_o   = tx_out_q;
  assign tx_ready_o = tx_ready_q;
  assign tx_busy_o  = tx_busy_q;
  assign tx_done_o  = tx_done_q;

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx -- self-checking bench for serial_tx (8-bit words, 4 clocks
// per bit). Expected line activity is built from the frame definition: a list
// of frame bits, each repeated CLKS_PER_BIT times, compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int DW = 8;
  localparam int C  = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_out;
  logic          tx_busy;
  logic          tx_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_out_o   (tx_out),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and let the accept edge happen (bounded wait for ready).
  task automatic present(input logic [DW-1:0] w);
    int guard;
    guard    = 0;
    tx_valid = 1'b1;
    tx_data  = w;
    while (tx_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("accept_ready", tx_ready, 1'b1);
    tick();
  endtask

  // Check one frame cycle by cycle, starting at cycle E+1.
  task automatic expect_frame(input logic [DW-1:0] w, input bit busy_valid,
                              input logic [DW-1:0] busy_w, input bit chain,
                              input logic [DW-1:0] next_w, input int abort_at);
    bit bits[$];
    int ones;
    int n_cyc;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (P == 1) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    n_cyc = bits.size() * C;
    for (int cyc = 0; cyc < n_cyc; cyc++) begin
      if (cyc == abort_at) return;
      check("frame_out", tx_out, bits[cyc / C]);
      check("frame_busy", tx_busy, 1'b1);
      check("frame_ready", tx_ready, 1'b0);
      check("frame_done", tx_done, 1'b0);
      if (cyc == n_cyc - 1) begin
        tx_valid = chain;
        tx_data  = chain ? next_w : DW'($urandom);
      end else begin
        tx_valid = busy_valid;
        tx_data  = busy_w;
      end
      tick();
    end
    check("end_done", tx_done, 1'b1);
    check("end_ready", tx_ready, 1'b1);
    check("end_busy", tx_busy, 1'b0);
    check("end_out", tx_out, 1'b1);
    if (!chain) begin
      tick();
      check("post_done", tx_done, 1'b0);
      check("post_out", tx_out, 1'b1);
      check("post_ready", tx_ready, 1'b1);
    end
  endtask

  initial begin
    logic [DW-1:0] words [16];
    bit            chains[16];
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset asserted before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_out", tx_out, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    repeat (3) tick();
    check("rst_hold_ready", tx_ready, 1'b1);
    check("rst_hold_out", tx_out, 1'b1);
    tx_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();
    check("idle_out", tx_out, 1'b1);
    check("idle_done", tx_done, 1'b0);

    // Directed frames.
    present(8'hA5);
    expect_frame(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, -1);
    present(8'h07);
    expect_frame(8'h07, 1'b1, 8'hFF, 1'b0, 8'h00, -1);

    // Back-to-back with valid held high.
    present(8'h3C);
    expect_frame(8'h3C, 1'b1, DW'($urandom), 1'b1, 8'hC3, -1);
    present(8'hC3);
    expect_frame(8'hC3, 1'b0, 8'h00, 1'b0, 8'h00, -1);

    // 0xFF offered during the DATA phase of a 0x00 frame, then reset mid-frame.
    present(8'h00);
    expect_frame(8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 3 * C + 2);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", tx_out, 1'b1);
    check("midrst_ready", tx_ready, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_done", tx_done, 1'b0);
    tx_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    repeat (2) begin
      tick();
      check("after_rst_done", tx_done, 1'b0);
      check("after_rst_out", tx_out, 1'b1);
      check("after_rst_ready", tx_ready, 1'b1);
    end
    present(8'h5A);
    expect_frame(8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, -1);

    // Randomized words, random back-to-back chaining and busy-time noise.
    for (int i = 0; i < 16; i++) begin
      words[i]  = DW'($urandom);
      chains[i] = (i < 15) ? bit'($urandom_range(0, 1)) : 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      present(words[i]);
      expect_frame(words[i], bit'($urandom_range(0, 1)), DW'($urandom),
                   chains[i], (i < 15) ? words[(i < 15) ? i + 1 : i] : 8'h00, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
